// File: rtl/io_pkg.sv
// Shared defaults and helpers for the board input conditioning path.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package io_pkg;

    localparam int SW_W_DEF       = 32;
    localparam int BTN_W_DEF      = 4;
    localparam int TICK_DIV_DEF   = 50000;
    localparam int STABLE_CNT_DEF = 4;

    // Prescaler counter width; a divide-by-1 still needs one bit of counter.
    function automatic int prescaler_w(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit synchroniser + sample-history debouncer with a registered rise pulse.
// Latency: 2 sync flops, then STABLE_CNT equal samples on i_tick before o_level moves.
// Backpressure: none; free-running on every cycle, state only advances on i_tick.
module debounce_bit
    import io_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_rise
);

    logic                  sync_1;
    logic                  sync_2;
    logic [STABLE_CNT-2:0] hist;
    logic [STABLE_CNT-1:0] window;
    logic                  level_nxt;

    // Current synchronised sample joined to the stored history forms the decision window.
    always_comb begin
        window = {hist, sync_2};
    end

    // Move only on a unanimous window; any mixed window keeps the previous level.
    always_comb begin
        level_nxt = o_level;
        if (&window) begin
            level_nxt = 1'b1;
        end else if (~|window) begin
            level_nxt = 1'b0;
        end
    end

    // Synchroniser runs every cycle; history, level and rise pulse update on ticks only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            hist    <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            sync_1 <= i_raw;
            sync_2 <= sync_1;
            o_rise <= 1'b0;
            if (i_tick) begin
                hist    <= window[STABLE_CNT-2:0];
                o_level <= level_nxt;
                o_rise  <= level_nxt & ~o_level;
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces slide switches and push-buttons; one-cycle press pulses.
// Latency: 2 + (STABLE_CNT-1)*TICK_DIV + 1 .. 2 + STABLE_CNT*TICK_DIV cycles pin-to-output.
// Backpressure: none; outputs are plain levels/pulses sampled by the input buffer.
module input_debouncer
    import io_pkg::*;
#(
    parameter int SW_W           = SW_W_DEF,
    parameter int BTN_W          = BTN_W_DEF,
    parameter int TICK_DIV       = TICK_DIV_DEF,
    parameter int STABLE_CNT     = STABLE_CNT_DEF,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SW_W-1:0]  i_sw_raw,
    input  logic [BTN_W-1:0] i_btn_raw,
    output logic [SW_W-1:0]  o_io_sw,
    output logic [BTN_W-1:0] o_io_btn,
    output logic [BTN_W-1:0] o_btn_press,
    output logic             o_tick
);

    localparam int               CNT_W    = prescaler_w(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [BTN_W-1:0] btn_in;
    logic [SW_W-1:0]  sw_rise_unused;

    // The sample is taken on the same edge the counter wraps, so no tick is skipped or doubled.
    assign tick = (cnt == CNT_LAST);

    // Buttons are normalised to pressed = 1 before they ever reach a flop.
    assign btn_in = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

    // Shared prescaler: counts 0..TICK_DIV-1 and mirrors the tick onto o_tick one edge later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + CNT_W'(1);
            o_tick <= tick;
        end
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_sw_raw[i]),
            .i_tick  (tick),
            .o_level (o_io_sw[i]),
            .o_rise  (sw_rise_unused[i])
        );
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        debounce_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (btn_in[i]),
            .i_tick  (tick),
            .o_level (o_io_btn[i]),
            .o_rise  (o_btn_press[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed checks of input_debouncer against a sample-window model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_input_debouncer;

    localparam int T  = 4;
    localparam int S  = 3;
    localparam int NB = 36;

    logic        clk;
    logic        rst;
    logic [31:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [3:0]  btn_press;
    logic        tick_o;

    input_debouncer #(
        .SW_W           (32),
        .BTN_W          (4),
        .TICK_DIV       (T),
        .STABLE_CNT     (S),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sw_raw    (sw_raw),
        .i_btn_raw   (btn_raw),
        .o_io_sw     (io_sw),
        .o_io_btn    (io_btn),
        .o_btn_press (btn_press),
        .o_tick      (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int press_cnt [4];

    // Reference model: pins seen two edges late, sampled every T-th edge after reset,
    // level follows a unanimous window of the last S samples.
    logic [NB-1:0] m_late1, m_late2;
    int            m_edges;
    logic [NB-1:0] m_samp [$];
    logic [NB-1:0] m_level;
    logic [3:0]    m_press;
    logic          m_tick;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic [NB-1:0] pins);
        logic [NB-1:0] all1, any1, prev;
        if (rst_v) begin
            m_late1 = '0;
            m_late2 = '0;
            m_edges = 0;
            m_samp.delete();
            for (int j = 0; j < S - 1; j++) m_samp.push_back('0);
            m_level = '0;
            m_press = '0;
            m_tick  = 1'b0;
        end else begin
            m_edges++;
            m_tick  = (m_edges % T) == 0;
            m_press = '0;
            if (m_tick) begin
                m_samp.push_back(m_late2);
                all1 = '1;
                any1 = '0;
                foreach (m_samp[j]) begin
                    all1 &= m_samp[j];
                    any1 |= m_samp[j];
                end
                prev    = m_level;
                m_level = (m_level | all1) & any1;
                m_press = m_level[NB-1 -: 4] & ~prev[NB-1 -: 4];
                void'(m_samp.pop_front());
            end
            m_late2 = m_late1;
            m_late1 = pins;
        end
    endtask

    // One clock edge: advance the model with the pins present at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_edge(rst, {~btn_raw, sw_raw});
        #1;
        check_eq("sw", {32'd0, io_sw}, {32'd0, m_level[31:0]});
        check_eq("btn", {60'd0, io_btn}, {60'd0, m_level[35:32]});
        check_eq("press", {60'd0, btn_press}, {60'd0, m_press});
        check_eq("tick", {63'd0, tick_o}, {63'd0, m_tick});
        for (int b = 0; b < 4; b++) press_cnt[b] += int'(btn_press[b]);
    endtask

    task automatic clear_press();
        for (int b = 0; b < 4; b++) press_cnt[b] = 0;
    endtask

    initial begin
        int first, lat, bad, changes, hit, hold;
        logic [31:0] prev_sw;

        rst     = 1'b1;
        sw_raw  = '0;
        btn_raw = 4'hF;
        clear_press();

        // Reset with buttons released
        repeat (3) step();
        check_eq("rst_outs", {27'd0, io_sw, io_btn, btn_press, tick_o}, 64'd0);
        rst   = 1'b0;
        first = 0;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            step();
            if (tick_o) first = i;
        end
        check_eq("tick_first", first, 4);
        repeat (5) step();

        // Clean press of button 0
        clear_press();
        btn_raw = 4'hE;
        lat     = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (io_btn[0] && lat == 0) begin
                lat = i;
                check_eq("press_aligned", {60'd0, btn_press}, 64'h1);
            end
        end
        check_eq("press_lat_in_range", {63'd0, (lat >= 11 && lat <= 14)}, 64'd1);
        repeat (20) step();
        check_eq("press_once", press_cnt[0], 1);

        // Bounce on button 1
        clear_press();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_raw[1] = ~btn_raw[1];
            step();
            if (io_btn[1]) bad++;
        end
        check_eq("bounce_held_low", bad, 0);
        check_eq("bounce_no_pulse", press_cnt[1], 0);
        btn_raw[1] = 1'b0;
        repeat (30) step();
        check_eq("bounce_settled", {63'd0, io_btn[1]}, 64'd1);
        check_eq("bounce_one_pulse", press_cnt[1], 1);

        // Switch bus step
        sw_raw  = 32'hA5A5_0F0F;
        changes = 0;
        bad     = 0;
        prev_sw = io_sw;
        for (int i = 0; i < 30; i++) begin
            step();
            if (io_sw !== prev_sw) changes++;
            if (io_sw != 32'd0 && io_sw != 32'hA5A5_0F0F) bad++;
            prev_sw = io_sw;
        end
        check_eq("sw_single_edge", changes, 1);
        check_eq("sw_no_partial", bad, 0);
        check_eq("sw_final", {32'd0, io_sw}, 64'hA5A5_0F0F);

        // Short glitch on switch 0
        sw_raw = '0;
        repeat (30) step();
        hit       = 0;
        sw_raw[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (io_sw[0]) hit++;
        end
        sw_raw[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (io_sw[0]) hit++;
        end
        check_eq("glitch_ignored", hit, 0);

        // Release all buttons, then reset in the middle of a press of button 2
        btn_raw = 4'hF;
        repeat (30) step();
        check_eq("release_level", {60'd0, io_btn}, 64'd0);
        clear_press();
        btn_raw = 4'hB;
        repeat (6) step();
        rst = 1'b1;
        step();
        check_eq("midrst_outs", {27'd0, io_sw, io_btn, btn_press, tick_o}, 64'd0);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (btn_press[2] && lat == 0) lat = i;
        end
        check_eq("midrst_lat_in_range", {63'd0, (lat >= 11 && lat <= 14)}, 64'd1);
        check_eq("midrst_one_pulse", press_cnt[2], 1);
        btn_raw = 4'hF;
        repeat (20) step();
        check_eq("release_no_pulse", press_cnt[2], 1);

        // Randomised traffic: random holds, short glitches and occasional resets
        for (int it = 0; it < 70; it++) begin
            case ($urandom_range(0, 9))
                0:       rst = 1'b1;
                1, 2:    sw_raw[$urandom_range(0, 31)] ^= 1'b1;
                3, 4:    btn_raw = 4'($urandom);
                default: begin
                    sw_raw  = $urandom;
                    btn_raw = 4'($urandom);
                end
            endcase
            hold = (rst == 1'b1) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 25));
            repeat (hold) step();
            rst = 1'b0;
        end
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
